// File: rtl/i2s_master_rx_if.sv
// Stereo sample output bus of the I2S master receiver.
// Latency: n/a (wires only); carries one left/right pair per transfer.
// Backpressure: valid/ready; the master holds the pair stable while out_ready is low.
//
// Signals:
//   out_left  - left sample, two's complement, DATA_W bits
//   out_right - right sample, two's complement, DATA_W bits
//   out_valid - a stereo pair is available
//   out_ready - consumer accepts the pair when high together with out_valid
`timescale 1ns/100ps
interface i2s_master_rx_if #(
    parameter int DATA_W = 24
);
    logic [DATA_W-1:0] out_left;
    logic [DATA_W-1:0] out_right;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output out_left,
        output out_right,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_left,
        input  out_right,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/i2s_master_rx.sv
// Master-mode I2S receiver: drives lrclk, oversamples bclk/sdin, deserializes 24-bit stereo.
// Latency: pair committed SYNC_STAGES+2 clk after the bclk rise carrying the right slot's last bit.
// Backpressure: single output register; a frame completing while the pair is unaccepted is dropped (sticky overflow).
//
// Ports:
//   clk      - system clock, >= 4x bclk; all logic runs on it
//   rst      - synchronous active-high reset
//   bclk     - I2S bit clock, asynchronous, oversampled
//   sdin     - codec serial data, launched on bclk falling edge
//   enable   - run control; low forces the framer idle and discards the partial frame
//   lrclk    - word select to codec (0 = left, 1 = right)
//   out_if   - output pair bus (out_left/out_right/out_valid/out_ready)
//   overflow - sticky flag: a completed frame was dropped
//   ovf_clr  - one-cycle pulse clearing overflow (a same-cycle new drop wins)
`timescale 1ns/100ps
module i2s_master_rx #(
    parameter int DATA_W      = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            bclk,
    input  logic            sdin,
    input  logic            enable,
    output logic            lrclk,
    i2s_master_rx_if.master out_if,
    output logic            overflow,
    input  logic            ovf_clr
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Last slot position that carries a data bit; positions are 1-based
    // because bit 0 of every slot is the I2S one-bit delay.
    localparam logic [4:0] P_LAST = 5'(DATA_W);

    // ------------------------------------------------------------------
    // Synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] bclk_sync_q;
    logic [SYNC_STAGES-1:0] sdin_sync_q;
    logic                   bclk_prev_q;
    logic                   bclk_s;
    logic                   sdin_s;
    logic                   bclk_rise;
    logic                   bclk_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            bclk_sync_q <= '0;
            sdin_sync_q <= '0;
            bclk_prev_q <= 1'b0;
        end else begin
            bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], bclk};
            sdin_sync_q <= {sdin_sync_q[SYNC_STAGES-2:0], sdin};
            bclk_prev_q <= bclk_s;
        end
    end

    assign bclk_s    = bclk_sync_q[SYNC_STAGES-1];
    // Same depth as bclk, so sdin_s is the pin value at the detected rise.
    assign sdin_s    = sdin_sync_q[SYNC_STAGES-1];
    assign bclk_rise = bclk_s & ~bclk_prev_q;
    assign bclk_fall = ~bclk_s & bclk_prev_q;

    // ------------------------------------------------------------------
    // Framer FSM and capture
    // ------------------------------------------------------------------
    state_t              state_q,     state_d;
    logic [5:0]          bit_cnt_q,   bit_cnt_d;
    logic                lrclk_q,     lrclk_d;
    logic [DATA_W-1:0]   shift_q,     shift_d;
    logic [DATA_W-1:0]   left_hold_q, left_hold_d;
    logic                commit_q,    commit_d;

    logic [4:0]          slot_pos;
    logic                in_slot;
    logic                slot_last;

    assign slot_pos  = bit_cnt_q[4:0];
    assign in_slot   = (slot_pos != 5'd0) && (slot_pos <= P_LAST);
    assign slot_last = (slot_pos == P_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            lrclk_q     <= 1'b0;
            shift_q     <= '0;
            left_hold_q <= '0;
            commit_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            lrclk_q     <= lrclk_d;
            shift_q     <= shift_d;
            left_hold_q <= left_hold_d;
            commit_q    <= commit_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        left_hold_d = left_hold_q;
        commit_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                bit_cnt_d = '0;
                // The fall that starts RUN is itself count 0 (left slot start).
                if (bclk_fall && enable) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!enable) begin
                    // Abort: partial frame is lost; any committed pair stays.
                    state_d   = S_IDLE;
                    bit_cnt_d = '0;
                end else begin
                    if (bclk_fall) begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                    if (bclk_rise && in_slot) begin
                        shift_d = DATA_W'({shift_q, sdin_s});
                        if (slot_last) begin
                            if (!bit_cnt_q[5]) begin
                                left_hold_d = shift_d;
                            end else begin
                                commit_d = 1'b1;
                            end
                        end
                    end
                end
            end
            default: begin
                state_d   = S_IDLE;
                bit_cnt_d = '0;
            end
        endcase

        // lrclk follows the count the current fall has just started.
        lrclk_d = (state_d == S_RUN) ? bit_cnt_d[5] : 1'b0;
    end

    // ------------------------------------------------------------------
    // Output register, handshake and overflow
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] out_left_q,  out_left_d;
    logic [DATA_W-1:0] out_right_q, out_right_d;
    logic              out_valid_q, out_valid_d;
    logic              overflow_q,  overflow_d;
    logic              xfer;
    logic              load;
    logic              drop;

    assign xfer = out_valid_q & out_if.out_ready;
    // A commit in the same cycle as an accept replaces the pair; not a drop.
    assign load = commit_q & (~out_valid_q | out_if.out_ready);
    assign drop = commit_q & out_valid_q & ~out_if.out_ready;

    always_comb begin
        out_left_d  = out_left_q;
        out_right_d = out_right_q;
        out_valid_d = out_valid_q;
        overflow_d  = overflow_q;

        if (load) begin
            out_left_d  = left_hold_q;
            out_right_d = shift_q;
            out_valid_d = 1'b1;
        end else if (xfer) begin
            out_valid_d = 1'b0;
        end

        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_left_q  <= '0;
            out_right_q <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            out_left_q  <= out_left_d;
            out_right_q <= out_right_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign lrclk            = lrclk_q;
    assign overflow         = overflow_q;
    assign out_if.out_left  = out_left_q;
    assign out_if.out_right = out_right_q;
    assign out_if.out_valid = out_valid_q;

endmodule

// File: tb/tb_i2s_master_rx.sv
// Directed bench for i2s_master_rx with a behavioural codec model.
// Latency: codec follows the framer's own bit count; pairs expected at count 56.
// Backpressure: out_ready driven per test step.
`timescale 1ns/100ps
module tb_i2s_master_rx;
    localparam int DATA_W = 24;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic bclk    = 1'b0;
    logic sdin    = 1'b0;
    logic enable  = 1'b0;
    logic ovf_clr = 1'b0;
    logic lrclk;
    logic overflow;

    i2s_master_rx_if #(.DATA_W(DATA_W)) out_if ();

    i2s_master_rx #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .bclk     (bclk),
        .sdin     (sdin),
        .enable   (enable),
        .lrclk    (lrclk),
        .out_if   (out_if),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    // 50 MHz system clock; ~3.07 MHz bclk whose edges never land on a clk edge.
    always #10 clk = ~clk;
    initial begin
        #7;
        forever #162.8 bclk = ~bclk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] pat_l(input int k);
        if (k == 0) return 24'h800001;
        return 24'(k * 32'h0013_5791) ^ 24'hC00003;
    endfunction

    function automatic logic [23:0] pat_r(input int k);
        if (k == 0) return 24'h7FFFFE;
        return 24'(k * 32'h0002_468B) ^ 24'h3FFFFC;
    endfunction

    // Bit the codec drives for frame position pos: slot bit 0 and the
    // filler after bit 24 carry junk the receiver must ignore.
    function automatic logic slot_bit(input int pos, input logic [23:0] l, input logic [23:0] r);
        int s;
        logic [23:0] w;
        s = pos % 32;
        w = (pos < 32) ? l : r;
        if (s >= 1 && s <= 24) return w[24 - s];
        return s[0];
    endfunction

    // ---------------- codec model ----------------
    int          cc        = 0;
    int          cur_frame = -1;
    bit          running   = 1'b0;
    bit          codec_on  = 1'b0;
    logic [23:0] cur_l     = '0;
    logic [23:0] cur_r     = '0;

    always @(negedge bclk) begin
        if (!codec_on) begin
            running = 1'b0;
            sdin    = 1'b0;
        end else begin
            if (!running) begin
                running = 1'b1;
                cc      = 0;
            end else begin
                cc = (cc + 1) % 64;
            end
            if (cc == 0) begin
                cur_frame++;
                cur_l = pat_l(cur_frame);
                cur_r = pat_r(cur_frame);
            end
            sdin = slot_bit(cc, cur_l, cur_r);
        end
    end

    // lrclk must be low for counts 0..31 and high for 32..63 of every frame.
    always @(posedge bclk) begin
        if (codec_on && running)
            chk("lrclk_slot", {63'd0, lrclk}, (cc >= 32) ? 64'd1 : 64'd0);
    end

    // ---------------- helpers ----------------
    task automatic enable_run();
        @(posedge bclk);
        @(negedge clk);
        enable   = 1'b1;
        codec_on = 1'b1;
    endtask

    task automatic stop_run();
        enable   = 1'b0;
        codec_on = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (out_if.out_valid !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {63'd0, out_if.out_valid}, 64'd1);
    endtask

    task automatic wait_pos(input int frame, input int pos, input string tag);
        int n;
        n = 0;
        while (!(cur_frame == frame && cc == pos) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {63'd0, (cur_frame == frame && cc == pos)}, 64'd1);
    endtask

    task automatic wait_bclk_rise(input int frame, input int pos, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(posedge bclk);
            hit = running && cur_frame == frame && cc == pos;
        end
        chk(tag, {63'd0, hit}, 64'd1);
    endtask

    task automatic idle_window(input int n, output int v_hi, output int l_hi);
        v_hi = 0;
        l_hi = 0;
        repeat (n) begin
            @(negedge clk);
            if (out_if.out_valid) v_hi++;
            if (lrclk) l_hi++;
        end
    endtask

    task automatic chk_pair(input string tag, input int k);
        chk({tag, "_left"},  {40'd0, out_if.out_left},  {40'd0, pat_l(k)});
        chk({tag, "_right"}, {40'd0, out_if.out_right}, {40'd0, pat_r(k)});
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int base;
        int fa;
        int fb;
        int ff;
        int v_hi;
        int l_hi;

        out_if.out_ready = 1'b0;

        // 1. Reset with bclk running, then enable=0 idle.
        repeat (5) @(negedge clk);
        chk("rst_lrclk",    {63'd0, lrclk},            64'd0);
        chk("rst_valid",    {63'd0, out_if.out_valid}, 64'd0);
        chk("rst_left",     {40'd0, out_if.out_left},  64'd0);
        chk("rst_right",    {40'd0, out_if.out_right}, 64'd0);
        chk("rst_overflow", {63'd0, overflow},         64'd0);
        rst = 1'b0;
        idle_window(1200, v_hi, l_hi);
        chk("idle_valid_hi", 64'(v_hi), 64'd0);
        chk("idle_lrclk_hi", 64'(l_hi), 64'd0);

        // 2. Basic frame: extreme-value pair, valid after right slot bit 24.
        enable_run();
        wait_valid("basic_valid");
        chk("basic_timing", 64'(cc), 64'd56);
        chk_pair("basic", 0);
        @(negedge clk) out_if.out_ready = 1'b1;
        @(negedge clk) out_if.out_ready = 1'b0;
        chk("basic_accepted", {63'd0, out_if.out_valid}, 64'd0);

        // 3. Back-to-back with out_ready held high.
        base = cur_frame;
        out_if.out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wait_valid("b2b_valid");
            chk_pair("b2b", base + 1 + k);
            @(negedge clk);
            chk("b2b_pulse", {63'd0, out_if.out_valid}, 64'd0);
        end
        chk("b2b_overflow", {63'd0, overflow}, 64'd0);
        out_if.out_ready = 1'b0;

        // 4. Backpressure across two completions.
        wait_valid("bp_valid");
        fa = cur_frame;
        chk_pair("bp_first", fa);
        wait_pos(fa + 1, 58, "bp_pos");
        chk("bp_held_valid", {63'd0, out_if.out_valid}, 64'd1);
        chk_pair("bp_held", fa);
        chk("bp_overflow", {63'd0, overflow}, 64'd1);
        @(negedge clk) out_if.out_ready = 1'b1;
        @(negedge clk) out_if.out_ready = 1'b0;
        chk("bp_drained", {63'd0, out_if.out_valid}, 64'd0);
        chk("bp_ovf_sticky", {63'd0, overflow}, 64'd1);
        @(negedge clk) ovf_clr = 1'b1;
        @(negedge clk) ovf_clr = 1'b0;
        chk("bp_ovf_clr", {63'd0, overflow}, 64'd0);

        // 5. Accept on exactly the commit clk: replace, no overflow.
        wait_valid("sim_valid");
        fb = cur_frame;
        wait_bclk_rise(fb + 1, 56, "sim_rise");
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_pair("sim_before", fb);
        out_if.out_ready = 1'b1;
        @(negedge clk);
        out_if.out_ready = 1'b0;
        chk("sim_valid_kept", {63'd0, out_if.out_valid}, 64'd1);
        chk_pair("sim_new", fb + 1);
        chk("sim_overflow", {63'd0, overflow}, 64'd0);
        @(negedge clk) out_if.out_ready = 1'b1;
        @(negedge clk);
        chk("sim_drained", {63'd0, out_if.out_valid}, 64'd0);

        // 6a. Abort via enable at count 40, then restart.
        wait_pos(cur_frame + 1, 40, "abort_pos");
        stop_run();
        @(negedge clk);
        chk("abort_lrclk", {63'd0, lrclk}, 64'd0);
        idle_window(1200, v_hi, l_hi);
        chk("abort_valid_hi", 64'(v_hi), 64'd0);
        chk("abort_lrclk_hi", 64'(l_hi), 64'd0);
        enable_run();
        wait_valid("abort_resume_valid");
        chk_pair("abort_resume", cur_frame);
        @(negedge clk);
        out_if.out_ready = 1'b0;

        // 6b. Reset mid-frame with a pending pair.
        wait_valid("rstmid_valid");
        ff = cur_frame;
        wait_pos(ff + 1, 40, "rstmid_pos");
        rst = 1'b1;
        stop_run();
        repeat (5) @(negedge clk);
        chk("rstmid_valid_clr", {63'd0, out_if.out_valid}, 64'd0);
        chk("rstmid_left",      {40'd0, out_if.out_left},  64'd0);
        chk("rstmid_lrclk",     {63'd0, lrclk},            64'd0);
        chk("rstmid_overflow",  {63'd0, overflow},         64'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        out_if.out_ready = 1'b1;
        enable_run();
        wait_valid("rstmid_resume_valid");
        chk_pair("rstmid_resume", cur_frame);
        chk("rstmid_resume_ovf", {63'd0, overflow}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/i2s_master_rx.md
Name: i2s_master_rx

Overview:
- Master-mode I2S receiver for the audio path. It consumes the 3.072 MHz bit clock from the audio PLL: 48 kHz × 64 bclk per frame, 32-bit slots.
- It generates the word-select (lrclk) for the codec/microphone and deserializes the codec's serial data into 24-bit stereo samples.
- Samples are presented to the fabric on a valid/ready interface in the system clock domain.
- bclk is treated as asynchronous data and oversampled by clk (50 MHz nominal).

Parameters:
- DATA_W, 24, sample width captured per slot, MSB first; legal range 1..31.
- SYNC_STAGES, 2, flip-flop depth of the bclk/sdin synchronizers; ≥2.

Ports:
- clk  in  1  system clock; single clock domain for all logic; must be ≥4× bclk.
- rst  in  1  reset, synchronous, active-high.
- bclk  in  1  I2S bit clock from the PLL output, asynchronous to clk.
- sdin  in  1  serial data from the codec, launched on bclk falling edge.
- enable  in  1  run control; low holds the framer idle.
- lrclk  out  1  word select to the codec; 0 = left slot, 1 = right slot.
- out_left  out  DATA_W  left sample, two's complement.
- out_right  out  DATA_W  right sample.
- out_valid  out  1  stereo pair available.
- out_ready  in  1  consumer accepts the pair when high with out_valid.
- overflow  out  1  sticky: a completed frame was dropped.
- ovf_clr  in  1  clears overflow (one-cycle pulse).

Behaviour:
- Reset (rst sampled high at clk edge):
  - lrclk=0, out_left=0, out_right=0, out_valid=0, overflow=0.
  - Bit counter cleared to 0; shift register cleared; synchronizer flops cleared.
  - Any partial frame is discarded.
- Synchronization: bclk and sdin each pass through SYNC_STAGES flops, plus one history flop on bclk for edge detection.
  - rise = sync_bclk & ~prev; fall = ~sync_bclk & prev. Each is a one-clk pulse.
  - Detection latency is SYNC_STAGES+1 clk after the pin edge.
  - sdin uses the same depth, so it stays aligned with the detected rise.
- Framer states: IDLE, RUN.
  - IDLE: bit_cnt=0, lrclk=0, shift register held. Go to RUN on the first fall with enable=1.
  - RUN: on each fall, bit_cnt (6 bits) increments modulo 64, wrapping 63→0. lrclk is registered from the new bit_cnt[5], so it changes at the falling edges that start counts 0 and 32.
  - RUN→IDLE when enable=0, checked at any clk. The partial frame is discarded; a pending out_valid pair is retained.
- Capture:
  - On rise, slot position p = bit_cnt[4:0].
  - For 1 ≤ p ≤ DATA_W, shift the synchronized sdin in at the LSB. This gives the I2S one-bit delay after each lrclk transition.
  - Bits at p=0 and p>DATA_W are ignored.
- Frame completion:
  - On the rise with p==DATA_W and bit_cnt[5]==0, latch the left holding register.
  - On the rise with p==DATA_W and bit_cnt[5]==1, the frame is complete; commit {left holding, shift} on the next clk.
- Handshake:
  - Transfer happens on a clk with out_valid & out_ready.
  - On commit, if out_valid==0 or out_ready==1 in that cycle: load out_left/out_right and set out_valid=1. This covers simultaneous accept and commit, which is not an overflow.
  - On commit with out_valid=1 and out_ready=0: the new frame is dropped, outputs hold the old pair, and overflow is set.
  - out_valid clears after a transfer when there is no same-cycle commit.
  - Outputs are stable while out_valid=1 and out_ready=0.
- overflow:
  - Cleared by ovf_clr.
  - If ovf_clr and a new overflow event occur in the same cycle, the set wins.
- First frame after entering RUN: its left slot starts at count 0. Because the framer drives lrclk, the frame is always aligned and there is no resync logic.
- Throughput: one pair per 64 bclk, i.e. about 1041 clk at 50 MHz. The output buffer is a single register with no FIFO.

Test Plan:
1. Reset/idle: rst high 5 clk with bclk toggling → all outputs 0, lrclk stays 0; enable=0 with bclk running → lrclk constant 0, out_valid never rises.
2. Basic frame: bclk 3.072 MHz, clk 50 MHz, enable=1, codec model sends L=0x800001, R=0x7FFFFE → out_valid rises after the right slot's 24th bit, out_left=0x800001, out_right=0x7FFFFE. lrclk has period 64 bclk and 50% duty.
3. Back-to-back with out_ready tied 1 → 10 consecutive pairs are received in order, each out_valid is a one-clk pulse, overflow stays 0.
4. Backpressure: out_ready=0 across two frame completions → the first pair is held unchanged and overflow=1; assert out_ready → first pair transfers; ovf_clr pulse → overflow=0.
5. Simultaneous: out_ready pulsed on exactly the commit clk while out_valid=1 → new pair loaded, out_valid stays 1, overflow stays 0.
6. Abort: drop enable at bit_cnt=40, re-enable later → no partial pair is emitted; the next pair is correct and lrclk restarts low. Repeat with rst mid-frame → same result, and out_valid is cleared.
